// File: rtl/taiko_pkg.sv
// -----------------------------------------------------------------------------
// taiko_pkg
// Shared definitions for the keypad front end and the menu/mode logic:
//   - kev_state_e : key event generator state encoding
//   - KEY_*       : key codes produced by the keypad scanner
//   - *_DEF       : default timing, in 40 MHz clk cycles
//   - max3()      : helper used to size a counter shared by several timeouts
// -----------------------------------------------------------------------------
package taiko_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DEB  = 3'd1,
        ST_HELD = 3'd2,
        ST_RPT  = 3'd3,
        ST_REL  = 3'd4
    } kev_state_e;

    localparam logic [4:0] KEY_LEFT  = 5'b00100;
    localparam logic [4:0] KEY_SEL   = 5'b00101;
    localparam logic [4:0] KEY_RIGHT = 5'b00110;

    localparam int KEY_W_DEF     = 5;
    localparam int DEB_CYC_DEF   = 400000;    // 10 ms
    localparam int REP_DELAY_DEF = 20000000;  // 500 ms
    localparam int REP_RATE_DEF  = 4000000;   // 100 ms

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/key_event_gen.sv
// -----------------------------------------------------------------------------
// key_event_gen
// Turns the scanner's level key code / press flag into single-cycle key events:
// debounced, one event per physical press, optional auto-repeat while held.
//
// Ports:
//   clk         in   system clock (40 MHz)
//   reset       in   asynchronous, active-low
//   key_code    in   current key code from the keypad scanner
//   key_press   in   high while any key is detected
//   repeat_en   in   enables auto-repeat, sampled every cycle
//   evt_valid   out  one-cycle pulse per key event
//   evt_code    out  code of the last event, held between events
//   evt_repeat  out  1 = auto-repeat event, 0 = fresh press
//   key_held    out  high while a debounced key is considered down
// -----------------------------------------------------------------------------
module key_event_gen
    import taiko_pkg::*;
#(
    parameter int KEY_W     = KEY_W_DEF,
    parameter int DEB_CYC   = DEB_CYC_DEF,
    parameter int REP_DELAY = REP_DELAY_DEF,
    parameter int REP_RATE  = REP_RATE_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [KEY_W-1:0] key_code,
    input  logic             key_press,
    input  logic             repeat_en,
    output logic             evt_valid,
    output logic [KEY_W-1:0] evt_code,
    output logic             evt_repeat,
    output logic             key_held
);

    // One counter serves every timeout; it only has to reach the largest
    // terminal value minus one and is cleared on every state entry.
    localparam int CNT_MAX = max3(DEB_CYC, REP_DELAY, REP_RATE);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] DEB_TERM   = CNT_W'(DEB_CYC - 1);
    localparam logic [CNT_W-1:0] DELAY_TERM = CNT_W'(REP_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_TERM  = CNT_W'(REP_RATE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    kev_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [KEY_W-1:0] cand_q;
    logic             evt_valid_q;
    logic [KEY_W-1:0] evt_code_q;
    logic             evt_repeat_q;
    logic             key_held_q;

    // HELD and RPT share their branch; only the repeat period differs.
    logic [CNT_W-1:0] rep_term;
    assign rep_term = (state_q == ST_RPT) ? RATE_TERM : DELAY_TERM;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            cand_q       <= '0;
            evt_valid_q  <= 1'b0;
            evt_code_q   <= '0;
            evt_repeat_q <= 1'b0;
            key_held_q   <= 1'b0;
        end else begin
            evt_valid_q <= 1'b0;
            // Branch order encodes priority: release > code change > timer.
            unique case (state_q)
                ST_IDLE: begin
                    if (key_press) begin
                        cand_q  <= key_code;
                        cnt_q   <= '0;
                        state_q <= ST_DEB;
                    end
                end

                ST_DEB: begin
                    if (!key_press) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else if (key_code != cand_q) begin
                        cand_q <= key_code;
                        cnt_q  <= '0;
                    end else if (cnt_q == DEB_TERM) begin
                        evt_valid_q  <= 1'b1;
                        evt_code_q   <= cand_q;
                        evt_repeat_q <= 1'b0;
                        key_held_q   <= 1'b1;
                        cnt_q        <= '0;
                        state_q      <= ST_HELD;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end

                ST_HELD, ST_RPT: begin
                    if (!key_press) begin
                        cnt_q   <= '0;
                        state_q <= ST_REL;
                    end else if (key_code != cand_q) begin
                        // Rolled onto another key without a release.
                        cand_q     <= key_code;
                        key_held_q <= 1'b0;
                        cnt_q      <= '0;
                        state_q    <= ST_DEB;
                    end else if (!repeat_en) begin
                        // Repeat timing restarts from scratch once re-enabled.
                        cnt_q   <= '0;
                        state_q <= ST_HELD;
                    end else if (cnt_q == rep_term) begin
                        evt_valid_q  <= 1'b1;
                        evt_code_q   <= cand_q;
                        evt_repeat_q <= 1'b1;
                        cnt_q        <= '0;
                        state_q      <= ST_RPT;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end

                ST_REL: begin
                    if (key_press) begin
                        cnt_q <= '0;
                        if (key_code == cand_q) begin
                            // Release bounce: same key is still down.
                            state_q <= ST_HELD;
                        end else begin
                            cand_q     <= key_code;
                            key_held_q <= 1'b0;
                            state_q    <= ST_DEB;
                        end
                    end else if (cnt_q == DEB_TERM) begin
                        key_held_q <= 1'b0;
                        cnt_q      <= '0;
                        state_q    <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end

                default: begin
                    key_held_q <= 1'b0;
                    cnt_q      <= '0;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

    assign evt_valid  = evt_valid_q;
    assign evt_code   = evt_code_q;
    assign evt_repeat = evt_repeat_q;
    assign key_held   = key_held_q;

endmodule

// File: tb/tb_key_event_gen.sv
module tb_key_event_gen;
    import taiko_pkg::*;

    localparam int KW  = 5;
    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RR  = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [KW-1:0] key_code = '0;
    logic          key_press = 1'b0;
    logic          repeat_en = 1'b0;
    logic          evt_valid;
    logic [KW-1:0] evt_code;
    logic          evt_repeat;
    logic          key_held;

    always #5 clk = ~clk;

    key_event_gen #(.KEY_W(KW), .DEB_CYC(DEB), .REP_DELAY(RD), .REP_RATE(RR)) dut (
        .clk       (clk),
        .reset     (reset),
        .key_code  (key_code),
        .key_press (key_press),
        .repeat_en (repeat_en),
        .evt_valid (evt_valid),
        .evt_code  (evt_code),
        .evt_repeat(evt_repeat),
        .key_held  (key_held)
    );

    typedef struct {
        int            cyc;
        logic [KW-1:0] code;
        logic          rpt;
    } exp_evt_t;

    exp_evt_t exp_q[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;   // index of the most recent rising edge

    // Reference model: phases with the edge index at which the phase (or its
    // current timing window) began; a timeout is "N edges since start".
    typedef enum {P_IDLE, P_DEB, P_DOWN, P_REPEATING, P_UP} phase_e;
    phase_e        ph = P_IDLE;
    int            t0 = 0;
    logic [KW-1:0] m_key = '0;
    logic [KW-1:0] m_last = '0;

    function automatic bit m_held();
        return (ph == P_DOWN) || (ph == P_REPEATING) || (ph == P_UP);
    endfunction

    function automatic void emit(input bit rpt);
        exp_evt_t e;
        e.cyc = cyc; e.code = m_key; e.rpt = rpt;
        exp_q.push_back(e);
        m_last = m_key;
    endfunction

    function automatic void model_edge(input logic p, input logic [KW-1:0] c,
                                       input logic r, input logic rs);
        int since;
        since = cyc - t0;
        if (!rs) begin
            ph = P_IDLE; t0 = cyc; m_key = '0; m_last = '0;
            return;
        end
        case (ph)
            P_IDLE: if (p) begin m_key = c; ph = P_DEB; t0 = cyc; end
            P_DEB: begin
                if (!p)              begin ph = P_IDLE; t0 = cyc; end
                else if (c != m_key) begin m_key = c; t0 = cyc; end
                else if (since == DEB) begin emit(1'b0); ph = P_DOWN; t0 = cyc; end
            end
            P_DOWN, P_REPEATING: begin
                if (!p)              begin ph = P_UP; t0 = cyc; end
                else if (c != m_key) begin m_key = c; ph = P_DEB; t0 = cyc; end
                else if (!r)         begin ph = P_DOWN; t0 = cyc; end
                else if (since == ((ph == P_REPEATING) ? RR : RD)) begin
                    emit(1'b1); ph = P_REPEATING; t0 = cyc;
                end
            end
            P_UP: begin
                if (p && c == m_key)  begin ph = P_DOWN; t0 = cyc; end
                else if (p)           begin m_key = c; ph = P_DEB; t0 = cyc; end
                else if (since == DEB) begin ph = P_IDLE; t0 = cyc; end
            end
            default: ph = P_IDLE;
        endcase
    endfunction

    function automatic void chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d (edge %0d)", name, got, want, cyc);
        end
    endfunction

    // Called just after a rising edge: apply inputs, let one edge happen,
    // advance the model, then check the level outputs.
    task automatic step(input logic p, input logic [KW-1:0] c, input logic r,
                        input logic rs);
        // An event registered on the previous edge is wiped by an async reset
        // before the monitor can sample it.
        if (!rs && reset && exp_q.size() > 0 && exp_q[$].cyc == cyc)
            void'(exp_q.pop_back());
        reset = rs; key_press = p; key_code = c; repeat_en = r;
        if (!rs) begin
            #1;
            chk("rst_valid", int'(evt_valid), 0);
            chk("rst_held", int'(key_held), 0);
            chk("rst_code", int'(evt_code), 0);
            chk("rst_rpt", int'(evt_repeat), 0);
        end
        @(posedge clk);
        cyc++;
        model_edge(p, c, r, rs);
        #1;
        chk("key_held", int'(key_held), int'(m_held()));
        chk("evt_code", int'(evt_code), int'(m_last));
    endtask

    task automatic hold(input int n, input logic p, input logic [KW-1:0] c,
                        input logic r);
        for (int i = 0; i < n; i++) step(p, c, r, 1'b1);
    endtask

    // Monitor: pops expected events when the DUT presents one.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            total++; bad++;
            $display("FAIL missing_evt got=none want=edge%0d code=%0d", exp_q[0].cyc, exp_q[0].code);
            void'(exp_q.pop_front());
        end
        if (evt_valid) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL spurious_evt got=edge%0d code=%0d want=none", cyc, evt_code);
            end else begin
                chk("evt_edge", cyc, exp_q[0].cyc);
                chk("evt_code_at_evt", int'(evt_code), int'(exp_q[0].code));
                chk("evt_repeat", int'(evt_repeat), int'(exp_q[0].rpt));
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [KW-1:0] codes [4];
        codes[0] = KEY_LEFT; codes[1] = KEY_SEL; codes[2] = KEY_RIGHT; codes[3] = 5'b10001;

        @(posedge clk); #1;
        // 1: reset, then a long press without repeat
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0);
        hold(20, 1'b1, KEY_RIGHT, 1'b0);
        hold(8, 1'b0, KEY_RIGHT, 1'b0);
        // 2: chatter shorter than the debounce window
        for (int i = 0; i < 4; i++) hold(2, (i % 2) == 0, KEY_RIGHT, 1'b0);
        hold(6, 1'b0, KEY_RIGHT, 1'b0);
        // 3: auto-repeat
        hold(40, 1'b1, KEY_LEFT, 1'b1);
        hold(8, 1'b0, KEY_LEFT, 1'b1);
        // 4: release bounce, then real release
        hold(8, 1'b1, KEY_SEL, 1'b0);
        hold(2, 1'b0, KEY_SEL, 1'b0);
        hold(4, 1'b1, KEY_SEL, 1'b0);
        hold(6, 1'b0, KEY_SEL, 1'b0);
        // 5: roll from one key to another while pressed
        hold(8, 1'b1, KEY_LEFT, 1'b0);
        hold(8, 1'b1, KEY_RIGHT, 1'b0);
        hold(6, 1'b0, KEY_RIGHT, 1'b0);
        // 6: reset in the middle of a debounce
        hold(3, 1'b1, KEY_SEL, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b1, KEY_SEL, 1'b0, 1'b0);
        hold(8, 1'b1, KEY_SEL, 1'b0);
        hold(6, 1'b0, KEY_SEL, 1'b0);
        // Random segments
        for (int s = 0; s < 300; s++) begin
            logic p, r, rs;
            logic [KW-1:0] c;
            int n;
            p  = ($urandom_range(0, 3) != 0);
            r  = $urandom_range(0, 1);
            c  = codes[$urandom_range(0, 3)];
            n  = $urandom_range(1, 14);
            rs = ($urandom_range(0, 39) != 0);
            if (!rs) step(p, c, r, 1'b0);
            else hold(n, p, c, r);
        end
        hold(8, 1'b0, '0, 1'b0);
        @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
